// File: rtl/io_map_pkg.sv
// I/O address map shared by the memory-mapped peripherals.
// An I/O access has addr[IO_BASE_bit] set; each register is then selected
// one-hot by a single further address bit.
package io_map_pkg;

   localparam int IO_BASE_bit = 8;
   localparam int IO_LEDS_bit = 2;
   localparam int IO_HEX_bit  = 3;
   localparam int IO_KEY_bit  = 4;
   localparam int IO_SW_bit   = 5;
   localparam int IO_EVT_bit  = 6;

   localparam int NKEYS_DEF = 4;
   localparam int NSW_DEF   = 10;

   // True when addr is an I/O access whose register-select bit sel is set.
   function automatic logic io_hit(input logic [31:0] a, input int unsigned sel);
      return a[IO_BASE_bit] & a[sel];
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-input conditioner: 2-flop synchroniser, debounce counter and
// stable-level flop.  rise_o is high for the cycle whose closing edge
// takes the stable level from 0 to 1.
//   clk, reset_n : clock, async active-low reset
//   raw_i        : asynchronous input (already in active-high polarity)
//   stable_o     : debounced level
//   rise_o       : stable 0->1 about to be taken on the next edge
module debounce_bit #(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o
);

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter only runs while the synchronised level disagrees with the
   // accepted one; any agreement restarts it, so short glitches are dropped.
   // It is reset on acceptance, so it never exceeds CNT_TC and cannot wrap.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_TC) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   // Taken from next-state so the event sets on the same edge as the level.
   assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/key_sw_io.sv
// KEY/SW input peripheral on the CPU I/O read path.
// Keys are inverted (pressed = 1), synchronised and debounced; switches are
// synchronised only.  Debounced presses latch into a sticky EVENT register
// cleared by writing 1s.
//   clk, reset_n : CPU clock, async active-low reset
//   key_raw      : board KEY pins, active-low, asynchronous
//   sw_raw       : board SW pins, active-high, asynchronous
//   addr         : CPU data address
//   memwrite     : CPU store strobe
//   writedata    : CPU store data
//   io_rdata     : read data (LEVEL 0x110, SW 0x120, EVENT 0x140)
//   irq          : high while any EVENT bit is set
module key_sw_io
   import io_map_pkg::*;
#(
   parameter int NKEYS    = NKEYS_DEF,
   parameter int NSW      = NSW_DEF,
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NKEYS-1:0] key_raw,
   input  logic [NSW-1:0]   sw_raw,
   input  logic [31:0]      addr,
   input  logic             memwrite,
   input  logic [31:0]      writedata,
   output logic [31:0]      io_rdata,
   output logic             irq
);

   if (DEBOUNCE < 1 || DEBOUNCE > 255 || DEBOUNCE > (2 ** CNT_W) - 1) begin : g_bad_debounce
      $error("key_sw_io: DEBOUNCE out of range for CNT_W");
   end

   logic [NKEYS-1:0] key_stable;
   logic [NKEYS-1:0] key_rise;
   logic [NSW-1:0]   sw_sync1_q;
   logic [NSW-1:0]   sw_sync2_q;
   logic [NKEYS-1:0] event_q;
   logic [NKEYS-1:0] event_d;
   logic [NKEYS-1:0] event_clr;
   logic             sel_key;
   logic             sel_sw;
   logic             sel_evt;

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      debounce_bit #(
         .DEBOUNCE (DEBOUNCE),
         .CNT_W    (CNT_W)
      ) u_debounce (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw_i    (~key_raw[i]),
         .stable_o (key_stable[i]),
         .rise_o   (key_rise[i])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
      end else begin
         sw_sync1_q <= sw_raw;
         sw_sync2_q <= sw_sync1_q;
      end
   end

   // Priority decode: KEY over SW over EVT, shared by reads and stores so a
   // store to an address that reads LEVEL or SW never touches EVENT.
   assign sel_key = io_hit(addr, IO_KEY_bit);
   assign sel_sw  = io_hit(addr, IO_SW_bit) & ~sel_key;
   assign sel_evt = io_hit(addr, IO_EVT_bit) & ~sel_key & ~sel_sw;

   assign event_clr = (memwrite && sel_evt) ? writedata[NKEYS-1:0] : '0;
   // A press arriving on the clearing edge survives.
   assign event_d   = (event_q & ~event_clr) | key_rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_q <= '0;
      end else begin
         event_q <= event_d;
      end
   end

   always_comb begin
      io_rdata = '0;
      if (sel_key) begin
         io_rdata[NKEYS-1:0] = key_stable;
      end else if (sel_sw) begin
         io_rdata[NSW-1:0] = sw_sync2_q;
      end else if (sel_evt) begin
         io_rdata[NKEYS-1:0] = event_q;
      end
   end

   assign irq = |event_q;

   logic unused_addr_wdata;
   assign unused_addr_wdata = ^{addr[31:9], addr[7], addr[3:0], writedata[31:NKEYS]};

endmodule

// File: tb/tb_key_sw_io.sv
module tb_key_sw_io;

   localparam int NK  = 4;
   localparam int NS  = 10;
   localparam int DEB = 3;
   localparam int CW  = 8;
   localparam int HL  = DEB + 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NK-1:0] key_raw;
   logic [NS-1:0] sw_raw;
   logic [31:0]   addr;
   logic          memwrite;
   logic [31:0]   writedata;
   logic [31:0]   io_rdata;
   logic          irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   key_sw_io #(
      .NKEYS    (NK),
      .NSW      (NS),
      .DEBOUNCE (DEB),
      .CNT_W    (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_raw   (key_raw),
      .sw_raw    (sw_raw),
      .addr      (addr),
      .memwrite  (memwrite),
      .writedata (writedata),
      .io_rdata  (io_rdata),
      .irq       (irq)
   );

   // Reference model: history of sampled "pressed" values per edge.
   // hist[j] is the value sampled j edges ago (hist[0] = this edge).
   // A key's accepted level flips at an edge when the DEB samples taken
   // 2..DEB+1 edges earlier all disagree with the current accepted level.
   logic [NK-1:0] hist [HL];
   logic [NK-1:0] m_stable;
   logic [NK-1:0] m_event;
   logic [NS-1:0] m_sw_prev;
   logic [NS-1:0] m_sw_vis;

   task automatic reset_model();
      for (int j = 0; j < HL; j++) hist[j] = '0;
      m_stable  = '0;
      m_event   = '0;
      m_sw_prev = '0;
      m_sw_vis  = '0;
   endtask

   task automatic step_model();
      logic [NK-1:0] clr;
      logic [NK-1:0] flip;
      logic          all_diff;
      clr = (memwrite && addr[8] && !addr[4] && !addr[5] && addr[6]) ? writedata[NK-1:0] : '0;
      for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = ~key_raw;
      flip = '0;
      for (int i = 0; i < NK; i++) begin
         all_diff = 1'b1;
         for (int j = 2; j < HL; j++)
            if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
         flip[i] = all_diff;
      end
      m_event   = (m_event & ~clr) | (flip & ~m_stable);
      m_stable  = m_stable ^ flip;
      m_sw_vis  = m_sw_prev;
      m_sw_prev = sw_raw;
   endtask

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      logic [31:0] r;
      r = 32'h0;
      if (a[8]) begin
         if (a[4])      r = 32'(m_stable);
         else if (a[5]) r = 32'(m_sw_vis);
         else if (a[6]) r = 32'(m_event);
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      reset_model();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) reset_model();
         else step_model();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cycle_rdata", io_rdata, exp_rd(addr));
         chk("cycle_irq", {31'b0, irq}, {31'b0, |m_event});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      addr      = a;
      writedata = d;
      memwrite  = 1'b1;
      tick(1);
      memwrite  = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(nm, io_rdata, exp);
   endtask

   initial begin
      reset_n   = 1'b0;
      key_raw   = '0;
      sw_raw    = '0;
      addr      = 32'h110;
      memwrite  = 1'b0;
      writedata = '0;

      // Reset with every key held pressed.
      tick(3);
      chk("rst_rdata", io_rdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick(1);
         chk("rst_level_hold", io_rdata, 32'h0);
      end
      tick(1);
      chk("rst_level_f", io_rdata, 32'hF);
      rd("rst_event_f", 32'h140, 32'hF);
      chk("rst_irq_set", {31'b0, irq}, 32'h1);
      key_raw = 4'hF;
      tick(6);
      store(32'h140, 32'hFFFF_FFFF);
      rd("clr_all", 32'h140, 32'h0);
      chk("clr_irq", {31'b0, irq}, 32'h0);

      // Clean press of key 1.
      key_raw = 4'b1101;
      addr    = 32'h110;
      for (int e = 0; e < 4; e++) begin
         tick(1);
         chk("press_hold", io_rdata, 32'h0);
      end
      tick(1);
      chk("press_level", io_rdata, 32'h2);
      rd("press_event", 32'h140, 32'h2);
      chk("press_irq", {31'b0, irq}, 32'h1);
      key_raw = 4'hF;
      tick(8);
      rd("release_event", 32'h140, 32'h2);
      rd("release_level", 32'h110, 32'h0);
      store(32'h140, 32'h2);
      rd("clr_k1", 32'h140, 32'h0);

      // Glitch of DEB-1 cycles is discarded.
      key_raw = 4'b1110;
      tick(2);
      key_raw = 4'hF;
      addr    = 32'h110;
      for (int e = 0; e < 8; e++) begin
         tick(1);
         chk("glitch_level", io_rdata, 32'h0);
      end
      rd("glitch_event", 32'h140, 32'h0);

      // A pulse of exactly DEB cycles is accepted.
      key_raw = 4'b1110;
      tick(3);
      key_raw = 4'hF;
      tick(8);
      rd("min_pulse_event", 32'h140, 32'h1);
      store(32'h140, 32'h1);

      // Write-1-to-clear.
      key_raw = 4'b0101;
      tick(6);
      key_raw = 4'hF;
      tick(6);
      rd("w1c_a", 32'h140, 32'hA);
      store(32'h140, 32'h8);
      rd("w1c_2", 32'h140, 32'h2);
      chk("w1c_irq1", {31'b0, irq}, 32'h1);
      store(32'h140, 32'hFFFF_FFFF);
      rd("w1c_0", 32'h140, 32'h0);
      chk("w1c_irq0", {31'b0, irq}, 32'h0);

      // Set wins over clear on the same edge.
      key_raw = 4'b1011;
      tick(4);
      addr      = 32'h140;
      writedata = 32'h4;
      memwrite  = 1'b1;
      tick(1);
      memwrite  = 1'b0;
      #1;
      chk("collide_event", io_rdata, 32'h4);
      chk("collide_irq", {31'b0, irq}, 32'h1);
      key_raw = 4'hF;
      tick(6);
      store(32'h140, 32'hF);

      // Switches and decode.
      sw_raw = 10'h2A5;
      addr   = 32'h120;
      tick(1);
      chk("sw_lat1", io_rdata, 32'h0);
      tick(1);
      chk("sw_lat2", io_rdata, 32'h2A5);
      rd("dec_100", 32'h100, 32'h0);
      rd("dec_0c0", 32'h0C0, 32'h0);
      rd("dec_150", 32'h150, 32'h0);

      // Store to LEVEL is ignored and does not touch EVENT.
      key_raw = 4'b1110;
      tick(6);
      rd("level_pre", 32'h110, 32'h1);
      store(32'h110, 32'hFFFF_FFFF);
      rd("level_post", 32'h110, 32'h1);
      rd("level_evt", 32'h140, 32'h1);
      key_raw = 4'hF;
      tick(6);
      store(32'h140, 32'hF);

      // Reset mid-debounce: key must re-qualify in full.
      key_raw = 4'b0111;
      addr    = 32'h110;
      tick(3);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_level", io_rdata, 32'h0);
      tick(2);
      reset_n = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick(1);
         chk("mid_rst_hold", io_rdata, 32'h0);
      end
      tick(1);
      chk("mid_rst_level8", io_rdata, 32'h8);

      // Randomised traffic, checked every cycle by the compare process.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 4) == 0) key_raw = key_raw ^ 4'(1 << $urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) sw_raw = 10'($urandom);
         case ($urandom_range(0, 7))
            0: addr = 32'h110;
            1: addr = 32'h120;
            2: addr = 32'h140;
            3: addr = 32'h140;
            4: addr = 32'h0C0;
            5: addr = 32'h150;
            6: addr = 32'h160;
            default: addr = $urandom;
         endcase
         memwrite  = ($urandom_range(0, 5) == 0);
         writedata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
         if (c == 1500) reset_n = 1'b0;
         if (c == 1503) reset_n = 1'b1;
         tick(1);
      end
      memwrite = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
